seg_scan_ctrl: RTL

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with frame-synchronous display update.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_scan_ctrl #(
  parameter int unsigned DWELL = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] din,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        pending,
  output logic        frame_tick
);

  typedef enum logic {GAP = 1'b0, DRIVE = 1'b1} state_t;

  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] disp_q, disp_d;
  logic [15:0] shadow_q, shadow_d;
  logic        pending_q, pending_d;
  logic        boundary;
  logic [3:0]  nibble;
  logic        lzb_blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    seg_decode = 7'b1111110;
      4'd1:    seg_decode = 7'b0110000;
      4'd2:    seg_decode = 7'b1101101;
      4'd3:    seg_decode = 7'b1111001;
      4'd4:    seg_decode = 7'b0110011;
      4'd5:    seg_decode = 7'b1011011;
      4'd6:    seg_decode = 7'b1011111;
      4'd7:    seg_decode = 7'b1110000;
      4'd8:    seg_decode = 7'b1111111;
      4'd9:    seg_decode = 7'b1111011;
      default: seg_decode = 7'b0000001;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= GAP;
      idx_q     <= 2'd0;
      cnt_q     <= 16'd0;
      disp_q    <= 16'h0000;
      shadow_q  <= 16'h0000;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      disp_q    <= disp_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
    end
  end

  assign boundary = (state_q == GAP) && (idx_q == 2'd0);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      GAP: begin
        state_d = DRIVE;
        cnt_d   = 16'd0;
      end
      DRIVE: begin
        if (cnt_q == DWELL_LAST) begin
          state_d = GAP;
          idx_d   = idx_q + 2'd1;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = GAP;
    endcase
  end

  // The display register only moves at the frame boundary so a frame never tears.
  always_comb begin
    disp_d    = disp_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (load) begin
      shadow_d = din;
    end
    if (boundary) begin
      pending_d = 1'b0;
      if (load) begin
        disp_d = din;
      end else if (pending_q) begin
        disp_d = shadow_q;
      end
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

`ifdef SEG_LZB_EN
  logic [3:0] nib_zero;
  logic [3:0] upper_zero;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lzb
      assign nib_zero[gi]   = (disp_q[gi*4 +: 4] == 4'd0);
      assign upper_zero[gi] = &nib_zero[3:gi];
    end
  endgenerate

  assign lzb_blank = (idx_q != 2'd0) && upper_zero[idx_q];
`else
  assign lzb_blank = 1'b0;
`endif

  assign nibble = disp_q[idx_q*4 +: 4];

  always_comb begin
    an  = 4'b1111;
    seg = 7'b0000000;
    if (!rst && (state_q == DRIVE) && !lzb_blank) begin
      an  = ~(4'b0001 << idx_q);
      seg = seg_decode(nibble);
    end
  end

  assign frame_tick = !rst && boundary;
  assign pending    = pending_q;

endmodule
